// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_buffer
//  Purpose  : IF/ID pipeline buffer. A DEPTH-entry FIFO of {pc, instr} pairs
//             with valid/ready handshakes on both sides. flush_i discards all
//             held entries and any entry presented in the same cycle.
//             if_ready_o comes from registered state only, so decode
//             back-pressure never reaches fetch combinationally.
//  Options  : define IF_ID_BUFFER_PERF_CNT_EN to add the flush_drop_cnt_o and
//             stall_cnt_o saturating performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_buffer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid_i,
    input  logic [ADDR_WIDTH-1:0]  if_pc_i,
    input  logic [INSTR_WIDTH-1:0] if_instr_i,
    output logic                   if_ready_o,
    input  logic                   flush_i,
    output logic                   id_valid_o,
    output logic [ADDR_WIDTH-1:0]  id_pc_o,
    output logic [INSTR_WIDTH-1:0] id_instr_o,
    input  logic                   id_ready_i
`ifdef IF_ID_BUFFER_PERF_CNT_EN
    ,
    output logic [31:0]            flush_drop_cnt_o,
    output logic [31:0]            stall_cnt_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0]  pc_mem_q    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic push;
    logic pop;

    // Handshake qualification: flush suppresses both push and pop
    assign if_ready_o = (count_q != FULL_CNT);
    assign id_valid_o = (count_q != '0);
    assign push       = if_valid_i && if_ready_o && !flush_i;
    assign pop        = id_valid_o && id_ready_i && !flush_i;

    // Head entry is masked to zero while empty so no stale or X data leaks out
    assign id_pc_o    = id_valid_o ? pc_mem_q[rd_ptr_q]    : '0;
    assign id_instr_o = id_valid_o ? instr_mem_q[rd_ptr_q] : '0;

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: only an accepted push writes, so held data is never disturbed
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem_q[wr_ptr_q]    <= if_pc_i;
            instr_mem_q[wr_ptr_q] <= if_instr_i;
        end
    end

`ifdef IF_ID_BUFFER_PERF_CNT_EN
    logic [31:0] flush_drop_cnt_q, flush_drop_cnt_d;
    logic [31:0] stall_cnt_q,      stall_cnt_d;
    logic [32:0] drop_sum;

    // Saturating counter updates: dropped entries per flush, and stalled fetch cycles
    always_comb begin
        drop_sum         = {1'b0, flush_drop_cnt_q} + 33'(count_q) + 33'(if_valid_i);
        flush_drop_cnt_d = flush_drop_cnt_q;
        stall_cnt_d      = stall_cnt_q;
        if (flush_i) begin
            flush_drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
        if (if_valid_i && !if_ready_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_drop_cnt_q <= '0;
            stall_cnt_q      <= '0;
        end else begin
            flush_drop_cnt_q <= flush_drop_cnt_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign flush_drop_cnt_o = flush_drop_cnt_q;
    assign stall_cnt_o      = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_buffer
//  Purpose  : Self-checking bench for if_id_buffer (DEPTH=2). Directed vector
//             table for the documented scenarios, then randomized traffic
//             against a queue-based reference model. Performance counters are
//             checked when IF_ID_BUFFER_PERF_CNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_valid_i;
    logic [AW-1:0] if_pc_i;
    logic [IW-1:0] if_instr_i;
    logic          if_ready_o;
    logic          flush_i;
    logic          id_valid_o;
    logic [AW-1:0] id_pc_o;
    logic [IW-1:0] id_instr_o;
    logic          id_ready_i;
`ifdef IF_ID_BUFFER_PERF_CNT_EN
    logic [31:0]   flush_drop_cnt_o;
    logic [31:0]   stall_cnt_o;
`endif

    always #5 clk = ~clk;

    if_id_buffer #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .DEPTH       (DEPTH)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .if_valid_i       (if_valid_i),
        .if_pc_i          (if_pc_i),
        .if_instr_i       (if_instr_i),
        .if_ready_o       (if_ready_o),
        .flush_i          (flush_i),
        .id_valid_o       (id_valid_o),
        .id_pc_o          (id_pc_o),
        .id_instr_o       (id_instr_o),
        .id_ready_i       (id_ready_i)
`ifdef IF_ID_BUFFER_PERF_CNT_EN
        ,
        .flush_drop_cnt_o (flush_drop_cnt_o),
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Directed vector: inputs for this cycle, expected outputs seen before the edge
    typedef struct {
        logic          rst;
        logic          v;
        logic [31:0]   pc;
        logic          flush;
        logic          rdy;
        logic          chk;
        logic          ev;
        logic [31:0]   epc;
        logic          er;
    } vec_t;

    // Reference model: a plain queue of accepted entries
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t   mq[$];
    longint m_drop;
    longint m_stall;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hFFFF_0000;
    endfunction

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] pc,
                                input logic f, input logic rd, input logic c,
                                input logic ev, input logic [31:0] epc, input logic er);
        vec_t t;
        t.rst = r; t.v = v; t.pc = pc; t.flush = f; t.rdy = rd;
        t.chk = c; t.ev = ev; t.epc = epc; t.er = er;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                         input logic f, input logic rd);
        rst        = r;
        if_valid_i = v;
        if_pc_i    = pc;
        if_instr_i = instr_of(pc);
        flush_i    = f;
        id_ready_i = rd;
    endtask

    // Advance one clock and apply the buffer rules to the model
    task automatic tick();
        int   sz;
        logic push_ok;
        @(posedge clk);
        sz = mq.size();
        if (rst) begin
            mq.delete();
            m_drop  = 0;
            m_stall = 0;
        end else begin
            if (if_valid_i && sz == DEPTH) m_stall++;
            if (flush_i) begin
                m_drop += sz + (if_valid_i ? 1 : 0);
                mq.delete();
            end else begin
                push_ok = if_valid_i && (sz < DEPTH);
                if (sz > 0 && id_ready_i) void'(mq.pop_front());
                if (push_ok) mq.push_back('{pc: if_pc_i, instr: if_instr_i});
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input vec_t t);
        drive(t.rst, t.v, t.pc, t.flush, t.rdy);
        #1;
        if (t.chk) begin
            chk("id_valid", {31'd0, id_valid_o}, {31'd0, t.ev});
            chk("id_pc",    id_pc_o,    t.ev ? t.epc : 32'd0);
            chk("id_instr", id_instr_o, t.ev ? instr_of(t.epc) : 32'd0);
            chk("if_ready", {31'd0, if_ready_o}, {31'd0, t.er});
        end
        tick();
    endtask

    task automatic check_model();
        logic [31:0] epc;
        logic [31:0] ein;
        epc = (mq.size() > 0) ? mq[0].pc    : 32'd0;
        ein = (mq.size() > 0) ? mq[0].instr : 32'd0;
        chk("m_id_valid", {31'd0, id_valid_o}, {31'd0, mq.size() != 0});
        chk("m_id_pc",    id_pc_o,    epc);
        chk("m_id_instr", id_instr_o, ein);
        chk("m_if_ready", {31'd0, if_ready_o}, {31'd0, mq.size() != DEPTH});
`ifdef IF_ID_BUFFER_PERF_CNT_EN
        chk("m_flush_drop", flush_drop_cnt_o, (m_drop  > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_drop[31:0]);
        chk("m_stall",      stall_cnt_o,      (m_stall > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_stall[31:0]);
`endif
    endtask

    localparam logic [31:0] P0  = 32'h1c00_0000;
    localparam logic [31:0] P1  = 32'h1c00_0004;
    localparam logic [31:0] P2  = 32'h1c00_0008;
    localparam logic [31:0] P10 = 32'h1c00_0010;
    localparam logic [31:0] P20 = 32'h1c00_0020;
    localparam logic [31:0] P24 = 32'h1c00_0024;
    localparam logic [31:0] P28 = 32'h1c00_0028;

    vec_t tbl[21];

    initial begin
        logic [31:0] prev_pc;
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        m_drop  = 0;
        m_stall = 0;

        //            rst   v     pc     fl    rdy   chk   ev    epc   er
        // streaming with decode always ready
        tbl[0]  = mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        tbl[1]  = mk(1'b0, 1'b1, P0,    1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        tbl[2]  = mk(1'b0, 1'b1, P1,    1'b0, 1'b1, 1'b1, 1'b1, P0,    1'b1);
        tbl[3]  = mk(1'b0, 1'b1, P2,    1'b0, 1'b1, 1'b1, 1'b1, P1,    1'b1);
        tbl[4]  = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, P2,    1'b1);
        tbl[5]  = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        // back-pressure: third push held while full, then drained in order
        tbl[6]  = mk(1'b0, 1'b1, P0,    1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        tbl[7]  = mk(1'b0, 1'b1, P1,    1'b0, 1'b0, 1'b1, 1'b1, P0,    1'b1);
        tbl[8]  = mk(1'b0, 1'b1, P2,    1'b0, 1'b0, 1'b1, 1'b1, P0,    1'b0);
        tbl[9]  = mk(1'b0, 1'b1, P2,    1'b0, 1'b1, 1'b1, 1'b1, P0,    1'b0);
        tbl[10] = mk(1'b0, 1'b1, P2,    1'b0, 1'b1, 1'b1, 1'b1, P1,    1'b1);
        tbl[11] = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, P2,    1'b1);
        // full buffer flushed with an incoming entry
        tbl[12] = mk(1'b0, 1'b1, P0,    1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        tbl[13] = mk(1'b0, 1'b1, P1,    1'b0, 1'b0, 1'b1, 1'b1, P0,    1'b1);
        tbl[14] = mk(1'b0, 1'b1, P10,   1'b1, 1'b0, 1'b1, 1'b1, P0,    1'b0);
        tbl[15] = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        // two-cycle flush pulse; only the post-flush push survives
        tbl[16] = mk(1'b0, 1'b1, P20,   1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        tbl[17] = mk(1'b0, 1'b1, P24,   1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        tbl[18] = mk(1'b0, 1'b1, P28,   1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        tbl[19] = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, P28,   1'b1);
        tbl[20] = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);

        @(negedge clk);
        for (int i = 0; i < 21; i++) begin
`ifdef IF_ID_BUFFER_PERF_CNT_EN
            if (i == 15) begin
                #1;
                chk("flush_drop_cnt", flush_drop_cnt_o, 32'd3);
                chk("stall_cnt",      stall_cnt_o,      32'd3);
            end
`endif
            run(tbl[i]);
        end

        // count=1 with simultaneous push/pop, repeated across pointer wrap
        run(mk(1'b0, 1'b1, 32'h1c00_002c, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1));
        prev_pc = 32'h1c00_002c;
        for (int k = 0; k < 10; k++) begin
            run(mk(1'b0, 1'b1, 32'h1c00_0030 + 32'(4 * k), 1'b0, 1'b1, 1'b1, 1'b1, prev_pc, 1'b1));
            prev_pc = 32'h1c00_0030 + 32'(4 * k);
        end
        run(mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, prev_pc, 1'b1));
        run(mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,   1'b1));

        // reset while full with decode ready, then a new stream
        run(mk(1'b0, 1'b1, P0,    1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1));
        run(mk(1'b0, 1'b1, P1,    1'b0, 1'b0, 1'b1, 1'b1, P0,    1'b1));
        run(mk(1'b1, 1'b1, P2,    1'b0, 1'b1, 1'b1, 1'b1, P0,    1'b0));
        run(mk(1'b0, 1'b1, 32'h1c00_0040, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1));
        run(mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1c00_0040, 1'b1));
        run(mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1));

        // randomized traffic against the queue model
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 9) < 7),
                  32'h1c00_0000 + 32'(4 * n),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 9) < 6));
            #1;
            check_model();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
